cordic_core: RTL and testbench
==============================

CORDIC_CORE -- requirements
Module: cordic_core

Interface
REQ-001 Parameter p_WIDTH, default 32: datapath width of x, y and z in bits.
REQ-002 Parameter p_ITERS, default 15: number of micro-rotations per operation.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 load  input  1  captures x_in, y_in, z_in, system and mode, and clears the iteration count.
REQ-006 iterate  input  1  performs one micro-rotation on this edge.
REQ-007 system  input  1  1 = circular, 0 = hyperbolic.
REQ-008 mode  input  1  1 = rotation (drive z to 0), 0 = vectoring (drive y to 0).
REQ-009 x_in, y_in  input  p_WIDTH  signed two's-complement fixed point; the core is agnostic to binary-point position.
REQ-010 z_in  input  p_WIDTH  signed angle; 2^p_WIDTH LSB = 360 deg, so 90 deg = 2^(p_WIDTH-2).
REQ-011 x_out, y_out, z_out  output  p_WIDTH  registered current state.
REQ-012 iter_idx  output  5  number of micro-rotations completed since load.
REQ-013 done  output  1  high when iter_idx == p_ITERS.
REQ-014 overflow  output  1  sticky overflow flag.

Function
REQ-015 On load, the core shall latch all inputs and clear iter_idx, done and overflow.
REQ-016 load and iterate in the same cycle: load shall win.
REQ-017 On iterate with done=0 and overflow=0, the state shall update in one cycle; results are visible on the outputs the cycle after.
REQ-018 On iterate with done=1 or overflow=1, the state shall hold.
REQ-019 Direction d: rotation mode, d = +1 if z >= 0 else -1; vectoring mode, d = +1 if y < 0 else -1.
REQ-020 Update equations: x' = x - m*d*(y >>> s); y' = y + d*(x >>> s); z' = z - d*A(s), with arithmetic shifts.
REQ-021 m = +1 for circular and -1 for hyperbolic.
REQ-022 Circular shift sequence: s = 0, 1, 2, … (s = iter_idx).
REQ-023 Hyperbolic shift sequence: starts at s = 1, with s = 4 and s = 13 each executed twice (1,2,3,4,4,5,…,13,13 for 15 steps).
REQ-024 A(s) shall be round(atan(2^-s)) in circular and round(atanh(2^-s)) in hyperbolic, in z units (rad * 2^(p_WIDTH-1)/pi).
REQ-025 No gain compensation: outputs include gain ≈1.64676 (circular) and ≈0.8298 (hyperbolic, 1/1.2051).
REQ-026 If the x' or y' add/sub exceeds the signed p_WIDTH range, overflow shall go high, x/y/z shall keep their pre-iteration values, and iter_idx shall not advance.
REQ-027 z arithmetic wraps modulo 2^p_WIDTH and shall not set overflow.
REQ-028 Convergence domain: |z| <= 99 deg (circular), |z| <= 60 deg (hyperbolic), |y| < |x| (hyperbolic vectoring). Outside it results are unspecified but deterministic.

Reset
REQ-029 rst high shall asynchronously clear x, y, z, iter_idx, done and overflow to 0, and latched system/mode to 0; outputs read 0 during reset.
REQ-030 Reset asserted mid-operation shall abort the operation; the first load after deassertion behaves normally.

Structure
REQ-031 Shared package cordic_pkg shall hold the atan/atanh LUT constants and the system/mode encodings.
REQ-032 One sub-module, cordic_angle_rom, shall map (system, s) to A(s); its output shall be combinational.

Verification
REQ-033 Circular rotation: x=0.6072529, y=0, z=45 deg (Q1.31), 15 iterates -> x≈0.7071, y≈0.7071, z≈0 (error <1e-3, <0.01 deg).
REQ-034 Circular vectoring: x=0, y=0.1, z=0 -> x≈0.1647, y≈0, z≈90 deg.
REQ-035 Hyperbolic rotation: x=1.2051364, y=0, z=23 deg (Q4.28) -> x≈1.0817, y≈0.4123, z≈0.
REQ-036 Hyperbolic vectoring: x=1, y=0.5, z=0 -> x≈0.7186, y≈0, z≈31.47 deg.
REQ-037 Overflow: circular rotation x=0.9, y=0.9, z=45 deg -> overflow=1 before done; state frozen; next load clears the flag.
REQ-038 Control and reset: load and iterate in the same cycle -> loaded values only; rst pulse mid-run -> all outputs 0 immediately without a clock edge; iterate while done=1 -> state unchanged.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared CORDIC constants: system/mode encodings, micro-rotation angle tables
// and the hyperbolic shift schedule.
package cordic_pkg;

  typedef enum logic {
    SYS_HYPERBOLIC = 1'b0,
    SYS_CIRCULAR   = 1'b1
  } system_e;

  typedef enum logic {
    MODE_VECTORING = 1'b0,
    MODE_ROTATION  = 1'b1
  } mode_e;

  localparam int unsigned LUT_W     = 32;
  localparam int unsigned LUT_DEPTH = 32;

  // round(atan(2^-s) * 2^31 / pi): angle units where 2^32 is a full turn
  localparam logic [LUT_W-1:0] ATAN_LUT [LUT_DEPTH] = '{
    32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
    32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
    32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  // round(atanh(2^-s) * 2^31 / pi); s = 0 is never scheduled
  localparam logic [LUT_W-1:0] ATANH_LUT [LUT_DEPTH] = '{
    32'd0,         32'd375486606, 32'd174591329, 32'd85894908,
    32'd42778589,  32'd21368373,  32'd10681577,  32'd5340462,
    32'd2670190,   32'd1335090,   32'd667544,    32'd333772,
    32'd166886,    32'd83443,     32'd41722,     32'd20861,
    32'd10430,     32'd5215,      32'd2608,      32'd1304,
    32'd652,       32'd326,       32'd163,       32'd81,
    32'd41,        32'd20,        32'd10,        32'd5,
    32'd3,         32'd1,         32'd1,         32'd0
  };

  // Hyperbolic schedule starts at s=1 and repeats s=4 and s=13 for convergence
  function automatic logic [4:0] hyp_shift(input logic [4:0] k);
    logic [4:0] s;
    s = k + 5'd1;
    if (k >= 5'd4)  s = s - 5'd1;
    if (k >= 5'd14) s = s - 5'd1;
    return s;
  endfunction

endpackage

// File: rtl/cordic_angle_rom.sv
// Combinational micro-rotation angle lookup A(s), rescaled from the 32-bit
// table to the datapath width.
module cordic_angle_rom
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32
) (
  input  system_e                     system_i,
  input  logic [4:0]                  shift_i,
  output logic signed [p_WIDTH-1:0]   angle_o
);

  localparam int unsigned SHL = (p_WIDTH > 32) ? p_WIDTH - 32 : 0;
  localparam int unsigned SHR = (p_WIDTH < 32) ? 32 - p_WIDTH : 0;
  localparam logic [63:0] RND = (64'd1 << SHR) >> 1;

  // Narrower datapaths round to nearest; wider ones pad with zero fraction
  function automatic logic signed [p_WIDTH-1:0] scale_angle(input logic [LUT_W-1:0] a);
    return $signed(p_WIDTH'((({32'd0, a} << SHL) + RND) >> SHR));
  endfunction

  logic [LUT_W-1:0] raw;

  always_comb begin
    raw = (system_i == SYS_CIRCULAR) ? ATAN_LUT[shift_i] : ATANH_LUT[shift_i];
  end

  assign angle_o = scale_angle(raw);

endmodule

// File: rtl/cordic_core.sv
// Iterative circular/hyperbolic CORDIC: one micro-rotation per iterate pulse,
// no gain compensation, sticky overflow that freezes the state.
module cordic_core
  import cordic_pkg::*;
#(
  parameter int p_WIDTH = 32,
  parameter int p_ITERS = 15
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load,
  input  logic                       iterate,
  input  logic                       system,
  input  logic                       mode,
  input  logic signed [p_WIDTH-1:0]  x_in,
  input  logic signed [p_WIDTH-1:0]  y_in,
  input  logic signed [p_WIDTH-1:0]  z_in,
  output logic signed [p_WIDTH-1:0]  x_out,
  output logic signed [p_WIDTH-1:0]  y_out,
  output logic signed [p_WIDTH-1:0]  z_out,
  output logic [4:0]                 iter_idx,
  output logic                       done,
  output logic                       overflow
);

  typedef logic signed [p_WIDTH-1:0] word_t;
  typedef logic signed [p_WIDTH:0]   wide_t;

  localparam logic [4:0] LAST = 5'(p_ITERS);

  function automatic wide_t add_sub(input word_t a, input word_t b, input logic sub);
    wide_t ae;
    wide_t be;
    ae = wide_t'(a);
    be = wide_t'(b);
    return sub ? ae - be : ae + be;
  endfunction

  function automatic logic out_of_range(input wide_t v);
    return v[p_WIDTH] != v[p_WIDTH-1];
  endfunction

  word_t      x_q, y_q, z_q, x_d, y_d, z_d;
  logic [4:0] iter_q, iter_d;
  logic       ovf_q, ovf_d;
  system_e    sys_q, sys_d;
  mode_e      mode_q, mode_d;

  logic [4:0] shift;
  word_t      angle, x_sh, y_sh, z_step;
  wide_t      x_step, y_step;
  logic       d_pos, step_ovf, done_w;

  assign shift = (sys_q == SYS_CIRCULAR) ? iter_q : hyp_shift(iter_q);

  cordic_angle_rom #(.p_WIDTH(p_WIDTH)) u_rom (
    .system_i (sys_q),
    .shift_i  (shift),
    .angle_o  (angle)
  );

  // d_pos means d = +1; x subtracts when m*d = +1 (circular, d=+1 or hyperbolic, d=-1)
  assign d_pos    = (mode_q == MODE_ROTATION) ? ~z_q[p_WIDTH-1] : y_q[p_WIDTH-1];
  assign x_sh     = x_q >>> shift;
  assign y_sh     = y_q >>> shift;
  assign x_step   = add_sub(x_q, y_sh, (sys_q == SYS_CIRCULAR) == d_pos);
  assign y_step   = add_sub(y_q, x_sh, ~d_pos);
  assign z_step   = d_pos ? z_q - angle : z_q + angle;
  assign step_ovf = out_of_range(x_step) | out_of_range(y_step);
  assign done_w   = (iter_q == LAST);

  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    iter_d = iter_q;
    ovf_d  = ovf_q;
    sys_d  = sys_q;
    mode_d = mode_q;
    if (load) begin
      x_d    = x_in;
      y_d    = y_in;
      z_d    = z_in;
      iter_d = 5'd0;
      ovf_d  = 1'b0;
      sys_d  = system_e'(system);
      mode_d = mode_e'(mode);
    end else if (iterate && !done_w && !ovf_q) begin
      if (step_ovf) begin
        ovf_d = 1'b1;
      end else begin
        x_d    = x_step[p_WIDTH-1:0];
        y_d    = y_step[p_WIDTH-1:0];
        z_d    = z_step;
        iter_d = iter_q + 5'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      iter_q <= '0;
      ovf_q  <= 1'b0;
      sys_q  <= SYS_HYPERBOLIC;
      mode_q <= MODE_VECTORING;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      z_q    <= z_d;
      iter_q <= iter_d;
      ovf_q  <= ovf_d;
      sys_q  <= sys_d;
      mode_q <= mode_d;
    end
  end

  assign x_out    = x_q;
  assign y_out    = y_q;
  assign z_out    = z_q;
  assign iter_idx = iter_q;
  assign done     = done_w;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_cordic_core.sv
// Bench for cordic_core: randomized and directed operations checked against
// closed-form trig/hyperbolic results scaled by the ideal CORDIC gain.
module tb_cordic_core;

  localparam int  N     = 15;
  localparam real SC1   = 2147483648.0;   // Q1.31
  localparam real SC4   = 268435456.0;    // Q4.28
  localparam real PI    = 3.14159265358979323846;
  localparam real TURN  = 4294967296.0;
  localparam real TOL   = 2.0e-3;
  localparam real ZTOL  = 0.02;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load = 1'b0, iterate = 1'b0, system = 1'b0, mode = 1'b0;
  logic signed [31:0] x_in = '0, y_in = '0, z_in = '0;
  logic signed [31:0] x_out, y_out, z_out;
  logic [4:0] iter_idx;
  logic done, overflow;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cordic_core #(.p_WIDTH(32), .p_ITERS(N)) dut (
    .clk(clk), .rst(rst), .load(load), .iterate(iterate),
    .system(system), .mode(mode),
    .x_in(x_in), .y_in(y_in), .z_in(z_in),
    .x_out(x_out), .y_out(y_out), .z_out(z_out),
    .iter_idx(iter_idx), .done(done), .overflow(overflow)
  );

  // ---------------- reference model helpers ----------------
  function automatic real fabs(input real v);
    return (v < 0.0) ? -v : v;
  endfunction

  function automatic real wrap_deg(input real d);
    real r = d;
    while (r > 180.0)   r = r - 360.0;
    while (r <= -180.0) r = r + 360.0;
    return r;
  endfunction

  function automatic real urand(input real lo, input real hi);
    return lo + (hi - lo) * real'($urandom_range(0, 100000)) / 100000.0;
  endfunction

  function automatic logic signed [31:0] fx(input real v, input real sc);
    return 32'($rtoi(v * sc));
  endfunction

  function automatic real rl(input logic signed [31:0] v, input real sc);
    return real'(v) / sc;
  endfunction

  function automatic real deg_of(input logic signed [31:0] z);
    return real'(z) * 360.0 / TURN;
  endfunction

  function automatic logic signed [31:0] z_of_deg(input real deg);
    return fx(deg / 360.0, TURN);
  endfunction

  function automatic real circ_gain(input int n);
    real g = 1.0;
    for (int s = 0; s < n; s++) g = g * $sqrt(1.0 + $pow(2.0, -2.0 * s));
    return g;
  endfunction

  // shift used by the k-th hyperbolic step: 1,2,3,4,4,5,...,13,13,14,...
  function automatic int hyp_seq(input int k);
    int s = 1;
    bit rep = 1'b0;
    for (int i = 0; i < k; i++) begin
      if ((s == 4 || s == 13) && !rep) rep = 1'b1;
      else begin s++; rep = 1'b0; end
    end
    return s;
  endfunction

  function automatic real hyp_gain(input int n);
    real g = 1.0;
    for (int k = 0; k < n; k++) g = g * $sqrt(1.0 - $pow(2.0, -2.0 * hyp_seq(k)));
    return g;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic do_load(input logic s, input logic m,
                         input logic signed [31:0] xv, yv, zv);
    @(negedge clk);
    system = s; mode = m; x_in = xv; y_in = yv; z_in = zv;
    load = 1'b1; iterate = 1'b0;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic do_iter(input int n);
    iterate = 1'b1;
    repeat (n) @(negedge clk);
    iterate = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({x_out, y_out, z_out, iter_idx, done, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_state: got x=%0d y=%0d z=%0d iter=%0d done=%0b ovf=%0b, want all 0",
               x_out, y_out, z_out, iter_idx, done, overflow);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_step();
    logic signed [31:0] a, b;
    for (int v = 0; v < 3; v++) begin
      a = 32'(int'($urandom_range(0, 1717986918)) - 858993459);
      b = 32'(int'($urandom_range(0, 858993459)) + 1);
      if (v == 0) do_load(1'b1, 1'b1, a, b, 32'sd536870912);
      else if (v == 1) do_load(1'b1, 1'b0, a, b, 32'sd0);
      else do_load(1'b0, 1'b1, a, b, 32'sd268435456);
      do_iter(1);
      n_vec++;
      if (v == 0 && {x_out, y_out, z_out, iter_idx} !== {a - b, a + b, 32'sd0, 5'd1}) begin
        n_err++;
        $display("FAIL step_circ_rot: got x=%0d y=%0d z=%0d iter=%0d, want x=%0d y=%0d z=0 iter=1",
                 x_out, y_out, z_out, iter_idx, a - b, a + b);
      end
      if (v == 1 && {x_out, y_out, z_out, iter_idx} !== {a + b, b - a, 32'sd536870912, 5'd1}) begin
        n_err++;
        $display("FAIL step_circ_vec: got x=%0d y=%0d z=%0d iter=%0d, want x=%0d y=%0d z=536870912 iter=1",
                 x_out, y_out, z_out, iter_idx, a + b, b - a);
      end
      if (v == 2 && {x_out, y_out, iter_idx} !== {a + (b >>> 1), b + (a >>> 1), 5'd1}) begin
        n_err++;
        $display("FAIL step_hyp_rot: got x=%0d y=%0d iter=%0d, want x=%0d y=%0d iter=1",
                 x_out, y_out, iter_idx, a + (b >>> 1), b + (a >>> 1));
      end
    end
  endtask

  task automatic test_circ_rotation();
    real xr, yr, zr, k, ex, ey;
    logic signed [31:0] xi, yi, zi;
    k = circ_gain(N);
    for (int v = 0; v < 6; v++) begin
      if (v == 0) begin
        xi = fx(0.6072529, SC1); yi = 0; zi = z_of_deg(45.0);
      end else begin
        xi = fx(urand(-0.35, 0.35), SC1); yi = fx(urand(-0.35, 0.35), SC1);
        zi = z_of_deg(urand(-90.0, 90.0));
      end
      do_load(1'b1, 1'b1, xi, yi, zi);
      do_iter(N);
      xr = rl(xi, SC1); yr = rl(yi, SC1); zr = real'(zi) * PI / (TURN / 2.0);
      ex = k * (xr * $cos(zr) - yr * $sin(zr));
      ey = k * (yr * $cos(zr) + xr * $sin(zr));
      n_vec++;
      if ({done, overflow, iter_idx} !== {1'b1, 1'b0, 5'(N)}) begin
        n_err++;
        $display("FAIL circ_rot_status[%0d]: got done=%0b ovf=%0b iter=%0d, want 1 0 %0d",
                 v, done, overflow, iter_idx, N);
      end
      n_vec++;
      if (fabs(rl(x_out, SC1) - ex) > TOL || fabs(rl(y_out, SC1) - ey) > TOL) begin
        n_err++;
        $display("FAIL circ_rot_xy[%0d]: got x=%f y=%f, want x=%f y=%f",
                 v, rl(x_out, SC1), rl(y_out, SC1), ex, ey);
      end
      n_vec++;
      if (fabs(wrap_deg(deg_of(z_out))) > ZTOL) begin
        n_err++;
        $display("FAIL circ_rot_z[%0d]: got %f deg, want 0", v, deg_of(z_out));
      end
      if (v == 0) begin
        n_vec++;
        if (fabs(rl(x_out, SC1) - 0.7071) > 1.0e-3 || fabs(rl(y_out, SC1) - 0.7071) > 1.0e-3) begin
          n_err++;
          $display("FAIL circ_rot_45deg: got x=%f y=%f, want 0.7071 0.7071",
                   rl(x_out, SC1), rl(y_out, SC1));
        end
      end
    end
  endtask

  task automatic test_circ_vectoring();
    real xr, yr, k, ex, ez;
    logic signed [31:0] xi, yi, zi;
    k = circ_gain(N);
    for (int v = 0; v < 6; v++) begin
      if (v == 0) begin
        xi = 0; yi = fx(0.1, SC1); zi = 0;
      end else if (v == 1) begin
        xi = fx(0.3, SC1); yi = fx(0.2, SC1); zi = z_of_deg(170.0);
      end else begin
        xi = fx(urand(0.1, 0.35), SC1); yi = fx(urand(-0.35, 0.35), SC1);
        zi = z_of_deg(urand(-45.0, 45.0));
      end
      do_load(1'b1, 1'b0, xi, yi, zi);
      do_iter(N);
      xr = rl(xi, SC1); yr = rl(yi, SC1);
      ex = k * $sqrt(xr * xr + yr * yr);
      ez = deg_of(zi) + $atan2(yr, xr) * 180.0 / PI;
      n_vec++;
      if ({done, overflow, iter_idx} !== {1'b1, 1'b0, 5'(N)}) begin
        n_err++;
        $display("FAIL circ_vec_status[%0d]: got done=%0b ovf=%0b iter=%0d, want 1 0 %0d",
                 v, done, overflow, iter_idx, N);
      end
      n_vec++;
      if (fabs(rl(x_out, SC1) - ex) > TOL || fabs(rl(y_out, SC1)) > TOL) begin
        n_err++;
        $display("FAIL circ_vec_xy[%0d]: got x=%f y=%f, want x=%f y=0", v, rl(x_out, SC1), rl(y_out, SC1), ex);
      end
      n_vec++;
      if (fabs(wrap_deg(deg_of(z_out) - ez)) > ZTOL) begin
        n_err++;
        $display("FAIL circ_vec_z[%0d]: got %f deg, want %f deg", v, deg_of(z_out), wrap_deg(ez));
      end
      if (v == 0) begin
        n_vec++;
        if (fabs(rl(x_out, SC1) - 0.1647) > 1.0e-3 || fabs(deg_of(z_out) - 90.0) > ZTOL) begin
          n_err++;
          $display("FAIL circ_vec_90deg: got x=%f z=%f, want 0.1647 90.0", rl(x_out, SC1), deg_of(z_out));
        end
      end
    end
  endtask

  task automatic test_hyp_rotation();
    real xr, yr, zr, k, ex, ey;
    logic signed [31:0] xi, yi, zi;
    k = hyp_gain(N);
    for (int v = 0; v < 5; v++) begin
      if (v == 0) begin
        xi = fx(1.2051364, SC4); yi = 0; zi = z_of_deg(23.0);
      end else begin
        xi = fx(urand(0.5, 1.5), SC4); yi = fx(urand(-0.4, 0.4), SC4);
        zi = z_of_deg(urand(-45.0, 45.0));
      end
      do_load(1'b0, 1'b1, xi, yi, zi);
      do_iter(N);
      xr = rl(xi, SC4); yr = rl(yi, SC4); zr = real'(zi) * PI / (TURN / 2.0);
      ex = k * (xr * (($exp(zr) + $exp(-zr)) / 2.0) + yr * (($exp(zr) - $exp(-zr)) / 2.0));
      ey = k * (yr * (($exp(zr) + $exp(-zr)) / 2.0) + xr * (($exp(zr) - $exp(-zr)) / 2.0));
      n_vec++;
      if ({done, overflow, iter_idx} !== {1'b1, 1'b0, 5'(N)}) begin
        n_err++;
        $display("FAIL hyp_rot_status[%0d]: got done=%0b ovf=%0b iter=%0d, want 1 0 %0d",
                 v, done, overflow, iter_idx, N);
      end
      n_vec++;
      if (fabs(rl(x_out, SC4) - ex) > TOL || fabs(rl(y_out, SC4) - ey) > TOL) begin
        n_err++;
        $display("FAIL hyp_rot_xy[%0d]: got x=%f y=%f, want x=%f y=%f",
                 v, rl(x_out, SC4), rl(y_out, SC4), ex, ey);
      end
      n_vec++;
      if (fabs(wrap_deg(deg_of(z_out))) > ZTOL) begin
        n_err++;
        $display("FAIL hyp_rot_z[%0d]: got %f deg, want 0", v, deg_of(z_out));
      end
    end
  endtask

  task automatic test_hyp_vectoring();
    real xr, yr, r, k, ex, ez;
    logic signed [31:0] xi, yi;
    k = hyp_gain(N);
    for (int v = 0; v < 5; v++) begin
      if (v == 0) begin
        xi = fx(1.0, SC4); yi = fx(0.5, SC4);
      end else begin
        xr = urand(0.5, 1.5);
        xi = fx(xr, SC4); yi = fx(xr * urand(-0.7, 0.7), SC4);
      end
      do_load(1'b0, 1'b0, xi, yi, 32'sd0);
      do_iter(N);
      xr = rl(xi, SC4); yr = rl(yi, SC4); r = yr / xr;
      ex = k * $sqrt(xr * xr - yr * yr);
      ez = 0.5 * $ln((1.0 + r) / (1.0 - r)) * 180.0 / PI;
      n_vec++;
      if ({done, overflow, iter_idx} !== {1'b1, 1'b0, 5'(N)}) begin
        n_err++;
        $display("FAIL hyp_vec_status[%0d]: got done=%0b ovf=%0b iter=%0d, want 1 0 %0d",
                 v, done, overflow, iter_idx, N);
      end
      n_vec++;
      if (fabs(rl(x_out, SC4) - ex) > TOL || fabs(rl(y_out, SC4)) > TOL) begin
        n_err++;
        $display("FAIL hyp_vec_xy[%0d]: got x=%f y=%f, want x=%f y=0", v, rl(x_out, SC4), rl(y_out, SC4), ex);
      end
      n_vec++;
      if (fabs(deg_of(z_out) - ez) > ZTOL) begin
        n_err++;
        $display("FAIL hyp_vec_z[%0d]: got %f deg, want %f deg", v, deg_of(z_out), ez);
      end
      if (v == 0) begin
        n_vec++;
        if (fabs(deg_of(z_out) - 31.47) > ZTOL) begin
          n_err++;
          $display("FAIL hyp_vec_31deg: got %f deg, want 31.47", deg_of(z_out));
        end
      end
    end
  endtask

  task automatic test_overflow();
    logic signed [31:0] xi, zi;
    xi = fx(0.9, SC1); zi = z_of_deg(45.0);
    do_load(1'b1, 1'b1, xi, xi, zi);
    do_iter(1);
    n_vec++;
    if ({overflow, done, iter_idx} !== {1'b1, 1'b0, 5'd0}) begin
      n_err++;
      $display("FAIL ovf_flag: got ovf=%0b done=%0b iter=%0d, want 1 0 0", overflow, done, iter_idx);
    end
    do_iter(4);
    n_vec++;
    if ({x_out, y_out, z_out, iter_idx, overflow} !== {xi, xi, zi, 5'd0, 1'b1}) begin
      n_err++;
      $display("FAIL ovf_frozen: got x=%0d y=%0d z=%0d iter=%0d ovf=%0b, want x=%0d y=%0d z=%0d iter=0 ovf=1",
               x_out, y_out, z_out, iter_idx, overflow, xi, xi, zi);
    end
    do_load(1'b1, 1'b1, fx(0.3, SC1), fx(0.1, SC1), zi);
    n_vec++;
    if ({overflow, iter_idx, done} !== {1'b0, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL ovf_cleared: got ovf=%0b iter=%0d done=%0b, want 0 0 0", overflow, iter_idx, done);
    end
  endtask

  task automatic test_load_priority();
    logic signed [31:0] xi, yi, zi;
    do_load(1'b1, 1'b1, fx(0.2, SC1), fx(0.1, SC1), z_of_deg(30.0));
    do_iter(3);
    xi = fx(urand(-0.3, 0.3), SC1); yi = fx(urand(-0.3, 0.3), SC1); zi = z_of_deg(urand(-60.0, 60.0));
    system = 1'b1; mode = 1'b1; x_in = xi; y_in = yi; z_in = zi;
    load = 1'b1; iterate = 1'b1;
    @(negedge clk);
    load = 1'b0; iterate = 1'b0;
    n_vec++;
    if ({x_out, y_out, z_out, iter_idx, done} !== {xi, yi, zi, 5'd0, 1'b0}) begin
      n_err++;
      $display("FAIL load_wins: got x=%0d y=%0d z=%0d iter=%0d, want x=%0d y=%0d z=%0d iter=0",
               x_out, y_out, z_out, iter_idx, xi, yi, zi);
    end
  endtask

  task automatic test_done_hold();
    real ex;
    do_load(1'b1, 1'b1, fx(0.6072529, SC1), 32'sd0, z_of_deg(45.0));
    do_iter(N + 4);
    ex = circ_gain(N) * rl(fx(0.6072529, SC1), SC1) * $cos(PI / 4.0);
    n_vec++;
    if ({done, iter_idx, overflow} !== {1'b1, 5'(N), 1'b0}) begin
      n_err++;
      $display("FAIL done_hold_status: got done=%0b iter=%0d ovf=%0b, want 1 %0d 0", done, iter_idx, overflow, N);
    end
    n_vec++;
    if (fabs(rl(x_out, SC1) - ex) > TOL || fabs(rl(y_out, SC1) - ex) > TOL) begin
      n_err++;
      $display("FAIL done_hold_xy: got x=%f y=%f, want %f %f", rl(x_out, SC1), rl(y_out, SC1), ex, ex);
    end
  endtask

  task automatic test_reset_midrun();
    real ex;
    do_load(1'b1, 1'b1, fx(0.3, SC1), fx(-0.2, SC1), z_of_deg(-50.0));
    iterate = 1'b1;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if ({x_out, y_out, z_out, iter_idx, done, overflow} !== '0) begin
      n_err++;
      $display("FAIL reset_async: got x=%0d y=%0d z=%0d iter=%0d done=%0b ovf=%0b, want all 0",
               x_out, y_out, z_out, iter_idx, done, overflow);
    end
    iterate = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    do_load(1'b1, 1'b1, fx(0.6072529, SC1), 32'sd0, z_of_deg(45.0));
    do_iter(N);
    ex = circ_gain(N) * rl(fx(0.6072529, SC1), SC1) * $cos(PI / 4.0);
    n_vec++;
    if ({done, iter_idx} !== {1'b1, 5'(N)} || fabs(rl(x_out, SC1) - ex) > TOL || fabs(rl(y_out, SC1) - ex) > TOL) begin
      n_err++;
      $display("FAIL reset_reload: got done=%0b iter=%0d x=%f y=%f, want 1 %0d %f %f",
               done, iter_idx, rl(x_out, SC1), rl(y_out, SC1), N, ex, ex);
    end
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_circ_rotation();
    test_circ_vectoring();
    test_hyp_rotation();
    test_hyp_vectoring();
    test_overflow();
    test_load_priority();
    test_done_hold();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
